// File: rtl/arcade_input_pkg.sv
// Shared types for the table-driven arcade input mapper: entry byte layout,
// per-bit drive modes and the decoded map-entry structure.
package arcade_input_pkg;

    localparam int JOY_W         = 32;
    localparam int ENT_VALID_BIT = 7;
    localparam int ENT_MODE_MSB  = 6;
    localparam int ENT_MODE_LSB  = 5;
    localparam int ENT_SRC_MSB   = 4;
    localparam int ENT_SRC_LSB   = 0;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_INV    = 2'b01,
        MODE_AUTO   = 2'b10,
        MODE_PULSE  = 2'b11
    } map_mode_e;

    typedef struct packed {
        logic       valid;
        map_mode_e  mode;
        logic [4:0] src;
    } map_entry_t;

    function automatic map_entry_t decode_entry(input logic [7:0] b);
        map_entry_t e;
        e.valid = b[ENT_VALID_BIT];
        e.mode  = map_mode_e'(b[ENT_MODE_MSB:ENT_MODE_LSB]);
        e.src   = b[ENT_SRC_MSB:ENT_SRC_LSB];
        return e;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_cell.sv
// One mapped output bit: decodes its table entry, detects source rising edges
// and owns the one-shot pulse counter. Produces the next-cycle bit value.
module input_bit_cell
    import arcade_input_pkg::*;
#(
    parameter int PULSE_TICKS = 3
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  map_entry_t       entry,
    input  logic [JOY_W-1:0] merged,
    input  logic [JOY_W-1:0] merged_prev,
    input  logic             tick,
    input  logic             phase,
    output logic             out_bit
);

    logic [2:0] cnt_q, cnt_d;
    logic       src_now;
    logic       src_rise;

    // A running pulse survives only while the selected entry stays in pulse mode.
    always_comb begin
        src_now  = merged[entry.src];
        src_rise = src_now & ~merged_prev[entry.src];
        cnt_d    = cnt_q;
        if (!entry.valid || entry.mode != MODE_PULSE) begin
            cnt_d = '0;
        end else if (cnt_q == 3'd0) begin
            if (src_rise) begin
                cnt_d = 3'(PULSE_TICKS);
            end
        end else if (tick) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_comb begin
        out_bit = 1'b0;
        if (entry.valid) begin
            case (entry.mode)
                MODE_DIRECT: out_bit = src_now;
                MODE_INV:    out_bit = ~src_now;
                MODE_AUTO:   out_bit = src_now & phase;
                MODE_PULSE:  out_bit = (cnt_d != 3'd0);
                default:     out_bit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Table-driven joystick-to-game-port mapper with two selectable banks,
// DIP byte overlay, shared autofire phase and per-bit one-shot pulses.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int NUM_PORTS      = 3,
    parameter int MAP_INDEX      = 2,
    parameter int DIP_INDEX      = 254,
    parameter int TICK_DIV       = 400000,
    parameter int AUTOFIRE_TICKS = 2,
    parameter int PULSE_TICKS    = 3
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [NUM_PLAYERS*32-1:0] joy,
    input  logic                      ioctl_download,
    input  logic                      ioctl_wr,
    input  logic [7:0]                ioctl_index,
    input  logic [24:0]               ioctl_addr,
    input  logic [7:0]                ioctl_dout,
    input  logic                      alt_sel,
    output logic [NUM_PORTS*8-1:0]    port_out,
    output logic                      map_loaded
);

    localparam int NB = NUM_PORTS * 8;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (AUTOFIRE_TICKS > 1) ? $clog2(AUTOFIRE_TICKS) : 1;

    map_entry_t           table_q [2][NB];
    map_entry_t           table_d [2][NB];
    logic [7:0]           dip_q [NUM_PORTS];
    logic [7:0]           dip_d [NUM_PORTS];
    logic [JOY_W-1:0]     merged_q, merged_d, merged_prev_q;
    logic                 alt_q;
    logic [PW-1:0]        presc_q, presc_d;
    logic                 tick;
    logic [AW-1:0]        af_cnt_q, af_cnt_d;
    logic                 phase_q, phase_d;
    logic                 dl_prev_q;
    logic                 seen_q, seen_d;
    logic                 map_loaded_q, map_loaded_d;
    logic [NB-1:0]        port_out_q, port_out_d;
    logic [NB-1:0]        cell_bit;
    map_entry_t           cell_entry [NB];
    logic                 map_wr;
    logic                 dip_wr;

    always_comb begin
        merged_d = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            merged_d = merged_d | joy[p*JOY_W +: JOY_W];
        end
    end

    // Out-of-range ports and any address above the 7-bit table window are dropped.
    always_comb begin
        map_wr = ioctl_wr && (ioctl_index == 8'(MAP_INDEX)) &&
                 (ioctl_addr[24:7] == '0) && (int'(ioctl_addr[5:3]) < NUM_PORTS);
        dip_wr = ioctl_wr && (ioctl_index == 8'(DIP_INDEX)) &&
                 (ioctl_addr[24:3] == '0) && (int'(ioctl_addr[2:0]) < NUM_PORTS);
        table_d = table_q;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NB; i++) begin
                if (map_wr && (ioctl_addr[6] == (b == 1)) && (ioctl_addr[5:0] == 6'(i))) begin
                    table_d[b][i] = decode_entry(ioctl_dout);
                end
            end
        end
        dip_d = dip_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (dip_wr && (ioctl_addr[2:0] == 3'(p))) begin
                dip_d[p] = ioctl_dout;
            end
        end
    end

    always_comb begin
        tick     = (presc_q == PW'(TICK_DIV - 1));
        presc_d  = tick ? '0 : presc_q + 1'b1;
        af_cnt_d = af_cnt_q;
        phase_d  = phase_q;
        if (tick) begin
            if (af_cnt_q == AW'(AUTOFIRE_TICKS - 1)) begin
                af_cnt_d = '0;
                phase_d  = ~phase_q;
            end else begin
                af_cnt_d = af_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        seen_d       = seen_q;
        map_loaded_d = map_loaded_q;
        if (ioctl_download && map_wr) begin
            seen_d = 1'b1;
        end
        if (dl_prev_q && !ioctl_download) begin
            map_loaded_d = map_loaded_q | seen_q;
            seen_d       = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            cell_entry[i] = alt_q ? table_q[1][i] : table_q[0][i];
        end
        port_out_d = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int b = 0; b < 8; b++) begin
                port_out_d[p*8+b] = cell_bit[p*8+b] | dip_q[p][b];
            end
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_cell
        input_bit_cell #(
            .PULSE_TICKS (PULSE_TICKS)
        ) u_cell (
            .clk_sys     (clk_sys),
            .reset_n     (reset_n),
            .entry       (cell_entry[g]),
            .merged      (merged_q),
            .merged_prev (merged_prev_q),
            .tick        (tick),
            .phase       (phase_q),
            .out_bit     (cell_bit[g])
        );
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NB; i++) begin
                    table_q[b][i] <= '0;
                end
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                dip_q[p] <= '0;
            end
            merged_q      <= '0;
            merged_prev_q <= '0;
            alt_q         <= 1'b0;
            presc_q       <= '0;
            af_cnt_q      <= '0;
            phase_q       <= 1'b0;
            dl_prev_q     <= 1'b0;
            seen_q        <= 1'b0;
            map_loaded_q  <= 1'b0;
            port_out_q    <= '0;
        end else begin
            table_q       <= table_d;
            dip_q         <= dip_d;
            merged_q      <= merged_d;
            merged_prev_q <= merged_q;
            alt_q         <= alt_sel;
            presc_q       <= presc_d;
            af_cnt_q      <= af_cnt_d;
            phase_q       <= phase_d;
            dl_prev_q     <= ioctl_download;
            seen_q        <= seen_d;
            map_loaded_q  <= map_loaded_d;
            port_out_q    <= port_out_d;
        end
    end

    assign port_out   = port_out_q;
    assign map_loaded = map_loaded_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench for arcade_input_mapper: stimulus queues expected port/flag
// values with a due cycle, a negedge monitor pops and compares them.
module tb_arcade_input_mapper;

    localparam int NP = 3;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic [63:0]       joy = '0;
    logic              ioctl_download = 1'b0;
    logic              ioctl_wr = 1'b0;
    logic [7:0]        ioctl_index = '0;
    logic [24:0]       ioctl_addr = '0;
    logic [7:0]        ioctl_dout = '0;
    logic              alt_sel = 1'b0;
    logic [NP*8-1:0]   port_out;
    logic              map_loaded;

    int n_compared = 0;
    int n_failed   = 0;
    int cyc        = 0;
    int mon_i;

    string       sb_name [$];
    logic [23:0] sb_mask [$];
    logic [23:0] sb_exp  [$];
    bit          sb_ml   [$];
    int          sb_due  [$];

    arcade_input_mapper #(
        .NUM_PLAYERS    (2),
        .NUM_PORTS      (NP),
        .MAP_INDEX      (2),
        .DIP_INDEX      (254),
        .TICK_DIV       (4),
        .AUTOFIRE_TICKS (2),
        .PULSE_TICKS    (3)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .joy            (joy),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .alt_sel        (alt_sel),
        .port_out       (port_out),
        .map_loaded     (map_loaded)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: actual 0x%06h required 0x%06h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expectPort(input string name, input logic [23:0] mask, input logic [23:0] val, input int due);
        sb_name.push_back(name);
        sb_mask.push_back(mask);
        sb_exp.push_back(val & mask);
        sb_ml.push_back(1'b0);
        sb_due.push_back(due);
    endtask

    task automatic expectMl(input string name, input logic val, input int due);
        sb_name.push_back(name);
        sb_mask.push_back(24'h1);
        sb_exp.push_back({23'b0, val});
        sb_ml.push_back(1'b1);
        sb_due.push_back(due);
    endtask

    // Monitor: every expectation whose due cycle has arrived is compared and retired.
    always @(negedge clk_sys) begin
        mon_i = 0;
        while (mon_i < sb_due.size()) begin
            if (sb_due[mon_i] <= cyc) begin
                if (sb_ml[mon_i])
                    checkOutput(sb_name[mon_i], {23'b0, map_loaded}, sb_exp[mon_i]);
                else
                    checkOutput(sb_name[mon_i], port_out & sb_mask[mon_i], sb_exp[mon_i]);
                sb_name.delete(mon_i);
                sb_mask.delete(mon_i);
                sb_exp.delete(mon_i);
                sb_ml.delete(mon_i);
                sb_due.delete(mon_i);
            end else begin
                mon_i++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [63:0] joy_v, input logic alt_v);
        joy     = joy_v;
        alt_sel = alt_v;
    endtask

    task automatic map_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = data;
        ioctl_wr    = 1'b1;
        step(1);
        ioctl_wr    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] jv;
        int          d, w, c, s, t, u;
        bit          seen1, found;

        jv = '0;
        step(3);
        expectPort("reset_port_out", 24'hFFFFFF, 24'h0, cyc);
        expectMl("reset_map_loaded", 1'b0, cyc);
        reset_n = 1'b1;
        step(2);

        // Direct entry: bank0 port0 bit3 <- src5, driven from player 1's word.
        map_write(8'd2, 25'h03, 8'h85);
        expectPort("direct_idle", 24'h000008, 24'h0, cyc + 1);
        jv[37] = 1'b1;
        applyStimulus(jv, 1'b0);
        expectPort("direct_early", 24'h000008, 24'h0, cyc + 1);
        expectPort("direct_rise", 24'h000008, 24'h000008, cyc + 2);
        step(3);
        d = cyc;
        map_write(8'd254, 25'h00, 8'h40);
        expectPort("dip_early", 24'h0000FF, 24'h08, d + 1);
        expectPort("dip_or", 24'h0000FF, 24'h48, d + 2);
        step(3);

        // Bank select on port1 bit0.
        map_write(8'd2, 25'h08, 8'h84);
        map_write(8'd2, 25'h48, 8'h81);
        jv[4] = 1'b1;
        jv[1] = 1'b0;
        applyStimulus(jv, 1'b0);
        step(3);
        expectPort("bank0_src4", 24'h000100, 24'h000100, cyc);
        applyStimulus(jv, 1'b1);
        expectPort("bank_switch_early", 24'h000100, 24'h000100, cyc + 1);
        expectPort("bank1_src1", 24'h000100, 24'h0, cyc + 2);
        step(3);
        applyStimulus(jv, 1'b0);
        expectPort("bank0_back", 24'h000100, 24'h000100, cyc + 2);
        step(3);

        // Inverted entry on port1 bit1, src2.
        w = cyc;
        map_write(8'd2, 25'h09, 8'hA2);
        expectPort("inv_unloaded", 24'h000200, 24'h0, w + 1);
        expectPort("inv_src_low", 24'h000200, 24'h000200, w + 2);
        step(2);
        jv[2] = 1'b1;
        applyStimulus(jv, 1'b0);
        expectPort("inv_early", 24'h000200, 24'h000200, cyc + 1);
        expectPort("inv_src_high", 24'h000200, 24'h0, cyc + 2);
        step(3);

        // Writes that must all be ignored.
        map_write(8'd2, 25'h18, 8'h85);
        map_write(8'd2, 25'h80, 8'h85);
        map_write(8'd2, 25'h100, 8'h85);
        map_write(8'd3, 25'h00, 8'h85);
        map_write(8'd254, 25'h08, 8'hFF);
        map_write(8'd254, 25'h03, 8'hFF);
        step(3);
        expectPort("ignored_writes", 24'hFFFFFF, 24'h000148, cyc);

        // map_loaded only after a download that carried a MAP write.
        expectMl("ml_before_dl", 1'b0, cyc);
        ioctl_download = 1'b1;
        step(1);
        map_write(8'd254, 25'h08, 8'h00);
        ioctl_download = 1'b0;
        step(3);
        expectMl("ml_no_map_write", 1'b0, cyc);
        ioctl_download = 1'b1;
        step(1);
        map_write(8'd2, 25'h12, 8'h00);
        step(1);
        expectMl("ml_during_dl", 1'b0, cyc);
        ioctl_download = 1'b0;
        expectMl("ml_after_fall", 1'b1, cyc + 2);
        step(3);

        // Autofire on port2 bit0, src4: 8-cycle half period.
        jv[4] = 1'b0;
        applyStimulus(jv, 1'b0);
        step(3);
        map_write(8'd2, 25'h10, 8'hC4);
        step(2);
        expectPort("af_idle", 24'h010000, 24'h0, cyc);
        jv[4] = 1'b1;
        applyStimulus(jv, 1'b0);
        seen1 = 1'b0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_sys);
            if (port_out[16]) begin
                seen1 = 1'b1;
            end else if (seen1) begin
                found = 1'b1;
                c     = cyc;
                break;
            end
        end
        checkOutput("af_phase_found", {23'b0, found}, 24'h1);
        if (found) begin
            expectPort("af_low_end", 24'h010000, 24'h0, c + 7);
            expectPort("af_high_start", 24'h010000, 24'h010000, c + 8);
            expectPort("af_high_end", 24'h010000, 24'h010000, c + 15);
            expectPort("af_low_again", 24'h010000, 24'h0, c + 16);
        end
        step(17);
        jv[4] = 1'b0;
        applyStimulus(jv, 1'b0);
        expectPort("af_release", 24'h010000, 24'h0, cyc + 2);
        step(3);

        // Pulse on port2 bit1, src11: one pulse of 9..12 cycles per press.
        map_write(8'd2, 25'h11, 8'hEB);
        step(2);
        s = cyc;
        jv[11] = 1'b1;
        applyStimulus(jv, 1'b0);
        expectPort("pulse_early", 24'h020000, 24'h0, s + 1);
        expectPort("pulse_start", 24'h020000, 24'h020000, s + 2);
        expectPort("pulse_min_len", 24'h020000, 24'h020000, s + 10);
        expectPort("pulse_max_len", 24'h020000, 24'h0, s + 14);
        expectPort("pulse_held_60", 24'h020000, 24'h0, s + 60);
        expectPort("pulse_held_100", 24'h020000, 24'h0, s + 100);
        step(100);
        jv[11] = 1'b0;
        applyStimulus(jv, 1'b0);
        step(5);
        t = cyc;
        jv[11] = 1'b1;
        applyStimulus(jv, 1'b0);
        expectPort("retrig_start", 24'h020000, 24'h020000, t + 2);
        expectPort("retrig_min_len", 24'h020000, 24'h020000, t + 10);
        expectPort("retrig_not_extended", 24'h020000, 24'h0, t + 14);
        expectPort("retrig_held", 24'h020000, 24'h0, t + 30);
        step(3);
        jv[11] = 1'b0;
        applyStimulus(jv, 1'b0);
        step(2);
        jv[11] = 1'b1;
        applyStimulus(jv, 1'b0);
        step(26);
        jv[11] = 1'b0;
        applyStimulus(jv, 1'b0);
        step(2);

        // Reset in the middle of a pulse clears outputs, table and DIPs.
        u = cyc;
        jv[11] = 1'b1;
        applyStimulus(jv, 1'b0);
        step(3);
        expectPort("pulse_before_reset", 24'h020000, 24'h020000, cyc);
        step(1);
        reset_n = 1'b0;
        expectPort("reset_mid_pulse", 24'hFFFFFF, 24'h0, cyc);
        expectMl("reset_ml_cleared", 1'b0, cyc);
        map_write(8'd2, 25'h03, 8'h85);
        step(2);
        reset_n = 1'b1;
        step(4);
        expectPort("table_cleared", 24'hFFFFFF, 24'h0, cyc);
        if (u < 0) $display("[TB] unexpected cycle count %0d", u);

        for (int i = 0; i < 200; i++) begin
            if (sb_due.size() == 0) break;
            step(1);
        end
        checkOutput("sb_drain", 24'(sb_due.size()), 24'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
